// File: rtl/rvc_asap_5pl_mem_region_ctrl.sv
// Q103H memory-region decoder and read-latency sequencer for the 5-stage core.
// Optional MEM_REGION_FAULT_EN adds the AccessFault / FaultAddr outputs for unmapped accesses.

module rvc_asap_5pl_mem_region_match #(
  parameter logic [31:0] BASE = '0,
  parameter logic [31:0] MASK = '0
) (
  input  logic [31:0] Addr,
  output logic        Hit
);
  assign Hit = (Addr & MASK) == BASE;
endmodule

module rvc_asap_5pl_mem_region_ctrl #(
  parameter int                          NUM_REGIONS = 4,
  parameter logic [32*NUM_REGIONS-1:0]   REGION_BASE = {32'h0000_3000, 32'h0000_2000,
                                                        32'h0000_1000, 32'h0040_0000},
  parameter logic [32*NUM_REGIONS-1:0]   REGION_MASK = {32'hFFFF_F000, 32'hFFFF_F000,
                                                        32'hFFFF_F000, 32'hFFC0_0000},
  parameter logic [4*NUM_REGIONS-1:0]    REGION_LAT  = {4'd2, 4'd0, 4'd0, 4'd0}
) (
  input  logic                          Clock,
  input  logic                          Rst,
  input  logic                          ReqValid,
  input  logic                          ReqWrEn,
  input  logic                          ReqRdEn,
  input  logic [31:0]                   ReqAddr,
  input  logic [31:0]                   ReqWrData,
  input  logic [3:0]                    ReqByteEn,
  output logic [NUM_REGIONS-1:0]        RegionSel,
  output logic [NUM_REGIONS-1:0]        RegionWrEn,
  output logic [NUM_REGIONS-1:0]        RegionRdEn,
  output logic [31:0]                   RegionAddr,
  output logic [31:0]                   RegionWrData,
  output logic [3:0]                    RegionByteEn,
  input  logic [32*NUM_REGIONS-1:0]     RegionRdData,
  output logic [31:0]                   RdDataQ104H,
  output logic                          RdDataValid,
  output logic                          Stall
`ifdef MEM_REGION_FAULT_EN
  ,
  output logic                          AccessFault,
  output logic [31:0]                   FaultAddr
`endif
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [NUM_REGIONS-1:0][3:0] LAT_A = REGION_LAT;

  logic [NUM_REGIONS-1:0]        hit_vec;
  logic [NUM_REGIONS-1:0][31:0]  rd_arr;
  logic                          dec_hit;
  logic [IDX_W-1:0]              dec_idx;
  logic [NUM_REGIONS-1:0]        dec_sel;
  logic [3:0]                    dec_lat;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hit_q, hit_d;
  logic [31:0]      rd_data_q;
  logic [31:0]      resp_data;
  logic             acc, rd_acc;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
    rvc_asap_5pl_mem_region_match #(
      .BASE (REGION_BASE[32*g +: 32]),
      .MASK (REGION_MASK[32*g +: 32])
    ) u_match (
      .Addr (ReqAddr),
      .Hit  (hit_vec[g])
    );
  end

  // Walk from the top so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    dec_sel = '0;
    if (dec_hit) dec_sel[dec_idx] = 1'b1;
  end

  assign dec_lat = dec_hit ? LAT_A[dec_idx] : 4'd0;
  assign rd_arr  = RegionRdData;

  assign Stall       = (state_q == S_WAIT);
  assign RdDataValid = (state_q == S_RESP);
  assign acc         = Rst & ReqValid & ~Stall;
  assign rd_acc      = acc & ReqRdEn;

  assign RegionSel    = Rst ? dec_sel : '0;
  assign RegionWrEn   = (acc & ReqWrEn) ? dec_sel : '0;
  assign RegionRdEn   = rd_acc ? dec_sel : '0;
  assign RegionAddr   = ReqAddr;
  assign RegionWrData = ReqWrData;
  assign RegionByteEn = ReqByteEn;

  // Read data is presented combinationally in RESP and held from the register afterwards.
  assign resp_data   = hit_q ? rd_arr[idx_q] : 32'h0;
  assign RdDataQ104H = RdDataValid ? resp_data : rd_data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      default: begin
        state_d = S_IDLE;
        if (rd_acc) begin
          idx_d = dec_idx;
          hit_d = dec_hit;
          if (dec_lat != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = dec_lat;
          end else begin
            state_d = S_RESP;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      rd_data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      if (RdDataValid) rd_data_q <= resp_data;
    end
  end

`ifdef MEM_REGION_FAULT_EN
  logic        fault_q;
  logic [31:0] fault_addr_q;
  logic        fault_now;

  assign fault_now = acc & (ReqRdEn | ReqWrEn) & ~dec_hit;

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      fault_q <= fault_now;
      if (fault_now) fault_addr_q <= ReqAddr;
    end
  end

  assign AccessFault = fault_q;
  assign FaultAddr   = fault_addr_q;
`endif

endmodule

// File: tb/tb_rvc_asap_5pl_mem_region_ctrl.sv
// Randomized + directed bench for rvc_asap_5pl_mem_region_ctrl against a cycle-count reference model.
// Build with MEM_REGION_FAULT_EN defined to also check AccessFault / FaultAddr.

module tb_rvc_asap_5pl_mem_region_ctrl;

  logic         Clock = 1'b0;
  logic         Rst;
  logic         ReqValid, ReqWrEn, ReqRdEn;
  logic [31:0]  ReqAddr, ReqWrData;
  logic [3:0]   ReqByteEn;
  logic [3:0]   RegionSel, RegionWrEn, RegionRdEn;
  logic [31:0]  RegionAddr, RegionWrData;
  logic [3:0]   RegionByteEn;
  logic [127:0] RegionRdData;
  logic [31:0]  RdDataQ104H;
  logic         RdDataValid, Stall;
`ifdef MEM_REGION_FAULT_EN
  logic         AccessFault;
  logic [31:0]  FaultAddr;
`endif

  rvc_asap_5pl_mem_region_ctrl dut (
    .Clock        (Clock),
    .Rst          (Rst),
    .ReqValid     (ReqValid),
    .ReqWrEn      (ReqWrEn),
    .ReqRdEn      (ReqRdEn),
    .ReqAddr      (ReqAddr),
    .ReqWrData    (ReqWrData),
    .ReqByteEn    (ReqByteEn),
    .RegionSel    (RegionSel),
    .RegionWrEn   (RegionWrEn),
    .RegionRdEn   (RegionRdEn),
    .RegionAddr   (RegionAddr),
    .RegionWrData (RegionWrData),
    .RegionByteEn (RegionByteEn),
    .RegionRdData (RegionRdData),
    .RdDataQ104H  (RdDataQ104H),
    .RdDataValid  (RdDataValid),
    .Stall        (Stall)
`ifdef MEM_REGION_FAULT_EN
    ,
    .AccessFault  (AccessFault),
    .FaultAddr    (FaultAddr)
`endif
  );

  always #5 Clock = ~Clock;

  // Region map as stated for the default configuration.
  logic [31:0] base_t [4] = '{32'h0040_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
  logic [31:0] mask_t [4] = '{32'hFFC0_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};
  int          lat_t  [4] = '{0, 0, 0, 2};

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          cyc = 0;
  int          stall_left = 0;
  bit          pend = 0;
  int          resp_at = 0;
  int          resp_reg = -1;
  logic [31:0] last_data = 32'h0;
  bit          fault_nxt = 0;
  logic [31:0] fault_addr_m = 32'h0;
  bit          rd_fixed = 0;
  logic        rst_drv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & mask_t[i]) == base_t[i]) return i;
    return -1;
  endfunction

  task automatic step(input bit v, input bit w, input bit r, input logic [31:0] a);
    int          d;
    logic [3:0]  exp_sel;
    bit          exp_stall, exp_vld, acc;
    logic [31:0] exp_data;
    @(negedge Clock);
    Rst       = rst_drv;
    ReqValid  = v;
    ReqWrEn   = w;
    ReqRdEn   = r;
    ReqAddr   = a;
    ReqWrData = $urandom;
    ReqByteEn = 4'($urandom);
    if (!rd_fixed)
      for (int k = 0; k < 4; k++) RegionRdData[32*k +: 32] = $urandom;
    #1;
    if (!Rst) begin
      stall_left   = 0;
      pend         = 0;
      last_data    = 32'h0;
      fault_nxt    = 0;
      fault_addr_m = 32'h0;
    end
    d         = decode(a);
    exp_sel   = (Rst && d >= 0) ? (4'b0001 << d) : 4'b0000;
    exp_stall = Rst && (stall_left > 0);
    exp_vld   = Rst && pend && (resp_at == cyc);
    exp_data  = exp_vld ? ((resp_reg >= 0) ? RegionRdData[32*resp_reg +: 32] : 32'h0) : last_data;
    acc       = Rst && v && !exp_stall;

    chk("sel",    {28'h0, RegionSel},  {28'h0, exp_sel});
    chk("wren",   {28'h0, RegionWrEn}, {28'h0, (acc && w) ? exp_sel : 4'b0000});
    chk("rden",   {28'h0, RegionRdEn}, {28'h0, (acc && r) ? exp_sel : 4'b0000});
    chk("addr",   RegionAddr,   a);
    chk("wdata",  RegionWrData, ReqWrData);
    chk("byteen", {28'h0, RegionByteEn}, {28'h0, ReqByteEn});
    chk("stall",  {31'h0, Stall},       {31'h0, exp_stall});
    chk("rvalid", {31'h0, RdDataValid}, {31'h0, exp_vld});
    chk("rdata",  RdDataQ104H, exp_data);
`ifdef MEM_REGION_FAULT_EN
    chk("fault",     {31'h0, AccessFault}, {31'h0, Rst && fault_nxt});
    chk("faultaddr", FaultAddr, fault_addr_m);
`endif

    @(posedge Clock);
    cyc++;
    if (exp_vld) begin
      last_data = exp_data;
      pend      = 0;
    end
    if (stall_left > 0) stall_left--;
    fault_nxt = acc && (w || r) && (d < 0);
    if (fault_nxt) fault_addr_m = a;
    if (acc && r) begin
      stall_left = (d >= 0) ? lat_t[d] : 0;
      resp_at    = cyc + stall_left;
      resp_reg   = d;
      pend       = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0:       a = 32'h0040_0000 | ($urandom & 32'h003F_FFFF);
      1:       a = 32'h0000_1000 | ($urandom & 32'h0000_0FFF);
      2:       a = 32'h0000_2000 | ($urandom & 32'h0000_0FFF);
      3:       a = 32'h0000_3000 | ($urandom & 32'h0000_0FFF);
      4:       a = $urandom;
      default: a = ($urandom_range(0, 1) != 0) ? 32'h0000_0FFF : 32'h0000_4000;
    endcase
    return a;
  endfunction

  initial begin
    Rst = 1'b0; ReqValid = 0; ReqWrEn = 0; ReqRdEn = 0;
    ReqAddr = 0; ReqWrData = 0; ReqByteEn = 0; RegionRdData = '0;

    // Reset state, including a request presented while in reset.
    rst_drv = 1'b0;
    idle(2);
    step(1, 1, 1, 32'h0000_1000);
    rst_drv = 1'b1;

    rd_fixed = 1;
    RegionRdData = {32'h1234_5678, 32'h2222_2222, 32'hDEAD_BEEF, 32'h00AA_00AA};

    // Zero-latency read from region 1.
    step(1, 0, 1, 32'h0000_1010);
    idle(2);
    chk("r1_hold", RdDataQ104H, 32'hDEAD_BEEF);

    // Two-wait-state read; requests during the stall must be ignored.
    step(1, 0, 1, 32'h0000_3004);
    step(1, 0, 1, 32'h0000_1000);
    step(1, 1, 1, 32'h0000_2000);
    idle(2);
    chk("r3_hold", RdDataQ104H, 32'h1234_5678);

    // Posted write, combined write+read, and a no-op request.
    step(1, 1, 0, 32'h0040_0100);
    step(1, 1, 1, 32'h0000_3000);
    idle(3);
    step(1, 0, 0, 32'h0000_3000);
    idle(2);

    // Unmapped read and write, plus mask boundaries.
    step(1, 0, 1, 32'h0900_0000);
    idle(1);
    step(1, 1, 0, 32'h0000_4000);
    idle(2);
    step(1, 0, 1, 32'h003F_FFFF);
    step(1, 0, 1, 32'h007F_FFFF);
    step(1, 0, 1, 32'h0000_0FFF);
    idle(2);

    // Reset while waiting on a slow read abandons it.
    step(1, 0, 1, 32'h0000_3004);
    rst_drv = 1'b0;
    idle(2);
    rst_drv = 1'b1;
    idle(5);
    step(1, 0, 1, 32'h0000_2000);
    idle(2);

    // Back-to-back reads.
    step(1, 0, 1, 32'h0000_1000);
    step(1, 0, 1, 32'h0000_2000);
    idle(2);

    // Randomized traffic with occasional resets.
    rd_fixed = 0;
    for (int n = 0; n < 800; n++) begin
      rst_drv = ($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) != 0, rand_addr());
    end
    rst_drv = 1'b1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvc_asap_5pl_mem_region_ctrl.md
RVC_ASAP_5PL_MEM_REGION_CTRL -- requirements
Module: rvc_asap_5pl_mem_region_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 4, number of decoded memory regions (1..8).
REQ-002 SHALL have parameter REGION_BASE, default {0x0000_3000, 0x0000_2000, 0x0000_1000, 0x0040_0000} packed 32b per region (region 0 in LSBs), region base address.
REQ-003 SHALL have parameter REGION_MASK, default {0xFFFF_F000, 0xFFFF_F000, 0xFFFF_F000, 0xFFC0_0000}, per-region 32b compare mask.
REQ-004 SHALL have parameter REGION_LAT, default {4'd2, 4'd0, 4'd0, 4'd0}, per-region read wait states (0..15).
REQ-005 SHALL have ports: Clock  in  1  core clock; rising edge only.
REQ-006 Rst  in  1  asynchronous, active-low reset.
REQ-007 ReqValid  in  1  Q103H access request; ReqWrEn in 1 write; ReqRdEn in 1 read (writeback).
REQ-008 ReqAddr  in  32  Q103H address (AluOut); ReqWrData in 32; ReqByteEn in 4.
REQ-009 RegionSel  out  NUM_REGIONS  one-hot Q103H select; RegionWrEn, RegionRdEn out NUM_REGIONS, per-region strobes.
REQ-010 RegionAddr out 32, RegionWrData out 32, RegionByteEn out 4: broadcast of request fields.
REQ-011 RegionRdData  in  32*NUM_REGIONS  per-region read data, region i in bits [32i+31:32i].
REQ-012 RdDataQ104H  out  32  returned read data; RdDataValid out 1 one-cycle pulse.
REQ-013 Stall  out  1  core must hold pipeline while high.

Function
REQ-014 Match[i] SHALL be (ReqAddr & REGION_MASK[i]) == REGION_BASE[i]; lowest index matching wins; result one-hot or all-zero (unmapped).
REQ-015 Request SHALL be accepted only when ReqValid=1 and Stall=0; RegionWrEn/RegionRdEn = accepted & ReqWrEn/ReqRdEn & RegionSel, single-cycle.
REQ-016 Writes SHALL be posted: no Stall, no RdDataValid.
REQ-017 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-018 IDLE: accepted read to region with LAT=0 -> RESP; LAT=N>0 -> WAIT with 4b counter loaded N; unmapped read -> RESP with data forced 0; otherwise stay IDLE.
REQ-019 WAIT: Stall=1; counter decrements each cycle; at counter==1 -> RESP next cycle; selected region index and RdEn held registered.
REQ-020 RESP: RdDataQ104H captured from RegionRdData of the registered region (0 if unmapped), RdDataValid=1 for this one cycle; Stall=0; new request accepted in same cycle (back-to-back); next state per REQ-018 for that request, else IDLE.
REQ-021 Latency: read accepted at cycle T SHALL give RdDataValid at T+1+LAT; Stall high exactly cycles T+1..T+LAT.
REQ-022 RdDataQ104H SHALL hold last captured value until next RESP.
REQ-023 ReqRdEn and ReqWrEn both high: write and read both issued; read timing per REQ-021.
REQ-024 ReqValid with neither RdEn nor WrEn: no strobes, no state change.

Reset
REQ-025 Rst low SHALL asynchronously force state IDLE, counter 0, RdDataQ104H 0, RdDataValid 0, Stall 0, registered region index 0, AccessFault 0, FaultAddr 0.
REQ-026 Reset during WAIT SHALL abandon the read: no RdDataValid after release.
REQ-027 RegionSel/strobes SHALL be 0 while Rst low.

Configuration
REQ-028 Macro MEM_REGION_FAULT_EN defined: outputs AccessFault (1b, one-cycle pulse at cycle after accepted unmapped access, read or write) and FaultAddr (32b, address of most recent unmapped access, sticky until reset) SHALL exist.
REQ-029 MEM_REGION_FAULT_EN undefined: ports AccessFault and FaultAddr absent; unmapped reads still return 0, unmapped writes silently dropped.

Verification
REQ-030 Read 0x0000_1010, RegionRdData[63:32]=0xDEAD_BEEF -> RegionSel=4'b0010 at T, RdDataValid at T+1, RdDataQ104H=0xDEAD_BEEF, Stall never high.
REQ-031 Read 0x0000_3004 (LAT=2), region 3 data 0x1234_5678 -> Stall high T+1,T+2; RdDataValid at T+3 with 0x1234_5678; second ReqValid during Stall ignored.
REQ-032 Write 0x0040_0100, data 0xA5A5_A5A5, ByteEn 4'b0011 -> RegionWrEn=4'b0001 one cycle, RegionByteEn=0011, no Stall, no RdDataValid.
REQ-033 Read 0x0900_0000 (unmapped) -> RdDataValid at T+1 with 0x0; with MEM_REGION_FAULT_EN AccessFault pulse and FaultAddr=0x0900_0000.
REQ-034 Read region 3, Rst low at T+1 -> Stall 0, state IDLE, no RdDataValid for 5 cycles after release; then read 0x0000_2000 completes at T'+1.
REQ-035 Back-to-back reads 0x0000_1000 then 0x0000_2000 on consecutive cycles -> two RdDataValid pulses on consecutive cycles with correct per-region data.
